addr_gen_regfile: RTL

Parametrised address-register file and address-generation unit for the CPU2908 executer, succeeding the fixed four-register 16-bit address bank and its offset adder. It holds NREG address registers of AW bits and loads/stores them byte-serially over the 8-bit internal bus. It issues effective addresses with zero-/sign-extended or full-width offsets, and performs post-increment / pre-decrement write-back in one command. All outputs are registered; the block sits between the instruction decoder (command port) and the external address bus.

---
 rtl/agu_pkg.sv | 29 ++
 rtl/agu_offset_ext.sv | 28 ++
 rtl/addr_gen_regfile.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/agu_pkg.sv
// Shared encodings for the CPU2908 address-generation unit: command opcodes,
// offset-extension modes and the byte-transfer state machine.
package agu_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_ADDR    = 3'd1,
    OP_POSTINC = 3'd2,
    OP_PREDEC  = 3'd3,
    OP_LOADB   = 3'd4,
    OP_STOREB  = 3'd5,
    OP_LEA     = 3'd6,
    OP_SETLIM  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    EXT_ZERO8 = 2'b00,
    EXT_SIGN8 = 2'b01,
    EXT_FULL  = 2'b10,
    EXT_NONE  = 2'b11
  } ext_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_e;

endpackage

// File: rtl/agu_offset_ext.sv
// Effective-address adder: base + extended offset + carry-in, modulo 2^AW.
// Shared by ADDR and LEA.
module agu_offset_ext
  import agu_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [1:0]    extMode,
  input  logic [AW-1:0] offset,
  input  logic [AW-1:0] base,
  input  logic          cyIn,
  output logic [AW-1:0] sum
);

  logic signed [AW-1:0] ext;

  always_comb begin
    ext = '0;
    case (ext_e'(extMode))
      EXT_ZERO8: ext = {{(AW-8){1'b0}}, offset[7:0]};
      EXT_SIGN8: ext = {{(AW-8){offset[7]}}, offset[7:0]};
      EXT_FULL:  ext = offset;
      default:   ext = '0;
    endcase
    sum = base + ext + {{(AW-1){1'b0}}, cyIn};
  end

endmodule

// File: rtl/addr_gen_regfile.sv
// Address-register file and AGU: NREG x AW registers, byte-serial load/store,
// offset addressing and post-inc/pre-dec. Optional stack limit: AGU_STACK_LIMIT_EN.
module addr_gen_regfile
  import agu_pkg::*;
#(
  parameter int AW   = 16,
  parameter int NREG = 4
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    cmdValid,
  output logic                    cmdReady,
  input  logic [2:0]              cmdOp,
  input  logic [$clog2(NREG)-1:0] cmdReg,
  input  logic [$clog2(NREG)-1:0] cmdDst,
  input  logic [1:0]              extMode,
  input  logic [AW-1:0]           offset,
  input  logic                    cyIn,
  input  logic                    stepWide,
  input  logic [7:0]              dataIn,
  output logic [AW-1:0]           addrOut,
  output logic                    addrValid,
  output logic [7:0]              dataOut,
  output logic                    dataValid,
  output logic                    err,
  output logic [AW-1:0]           spMon
);

  localparam int RW = $clog2(NREG);
  localparam int NB = AW / 8;
  localparam int BW = $clog2(NB);

  state_e          state_q;
  logic [BW-1:0]   beat_q;
  logic [RW-1:0]   ld_reg_q;
  logic [AW-1:0]   stage_q;
  logic [AW-1:0]   snap_q;
  logic [AW-1:0]   regs_q [NREG];
  logic [AW-1:0]   addr_q;
  logic            addrv_q;
  logic [7:0]      dout_q;
  logic            dval_q;
  logic            err_q;
`ifdef AGU_STACK_LIMIT_EN
  logic [AW-1:0]   limit_q;
`endif

  logic [AW-1:0]   base;
  logic [AW-1:0]   step;
  logic [AW-1:0]   inc;
  logic [AW-1:0]   dec;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   stage_d;
  logic            last_beat;
  logic            pd_block;
  logic            accept;

  agu_offset_ext #(.AW(AW)) u_ext (
    .extMode (extMode),
    .offset  (offset),
    .base    (base),
    .cyIn    (cyIn),
    .sum     (sum)
  );

  always_comb begin
    base      = regs_q[cmdReg];
    step      = stepWide ? AW'(2) : AW'(1);
    inc       = base + step;
    dec       = base - step;
    stage_d   = stage_q;
    stage_d[{beat_q, 3'b000} +: 8] = dataIn;
    last_beat = (beat_q == BW'(NB-1));
    accept    = cmdValid && cmdReady;
`ifdef AGU_STACK_LIMIT_EN
    // Underflow past zero counts as a violation even when the wrapped value is above the limit.
    pd_block  = (cmdReg == RW'(NREG-1)) && ((base < step) || (dec < limit_q));
`else
    pd_block  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      ld_reg_q <= '0;
      stage_q  <= '0;
      snap_q   <= '0;
      addr_q   <= '0;
      addrv_q  <= 1'b0;
      dout_q   <= '0;
      dval_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef AGU_STACK_LIMIT_EN
      limit_q  <= '0;
`endif
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      addrv_q <= 1'b0;
      dval_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          case (op_e'(cmdOp))
            OP_ADDR: begin
              addr_q  <= sum;
              addrv_q <= 1'b1;
            end
            OP_POSTINC: begin
              addr_q         <= base;
              addrv_q        <= 1'b1;
              regs_q[cmdReg] <= inc;
            end
            OP_PREDEC: begin
              if (pd_block) begin
                err_q <= 1'b1;
              end else begin
                addr_q         <= dec;
                addrv_q        <= 1'b1;
                regs_q[cmdReg] <= dec;
              end
            end
            OP_LEA: regs_q[cmdDst] <= sum;
            OP_LOADB: begin
              stage_q  <= stage_d;
              ld_reg_q <= cmdReg;
              beat_q   <= BW'(1);
              state_q  <= LOAD;
            end
            OP_STOREB: begin
              dout_q  <= base[7:0];
              dval_q  <= 1'b1;
              snap_q  <= base >> 8;
              beat_q  <= BW'(1);
              state_q <= STORE;
            end
`ifdef AGU_STACK_LIMIT_EN
            OP_SETLIM: limit_q <= offset;
`else
            OP_SETLIM: err_q <= 1'b1;
`endif
            default: ;
          endcase
        end
        LOAD: if (accept) begin
          // Any non-LOADB command mid-load is consumed as an abort.
          if (op_e'(cmdOp) == OP_LOADB && last_beat) begin
            regs_q[ld_reg_q] <= stage_d;
            stage_q          <= '0;
            beat_q           <= '0;
            state_q          <= IDLE;
          end else if (op_e'(cmdOp) == OP_LOADB) begin
            stage_q <= stage_d;
            beat_q  <= beat_q + BW'(1);
          end else begin
            err_q   <= 1'b1;
            stage_q <= '0;
            beat_q  <= '0;
            state_q <= IDLE;
          end
        end
        STORE: begin
          dout_q <= snap_q[7:0];
          dval_q <= 1'b1;
          snap_q <= snap_q >> 8;
          if (last_beat) begin
            beat_q  <= '0;
            state_q <= IDLE;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmdReady  = (state_q != STORE);
  assign addrOut   = addr_q;
  assign addrValid = addrv_q;
  assign dataOut   = dout_q;
  assign dataValid = dval_q;
  assign err       = err_q;
  assign spMon     = regs_q[NREG-1];

endmodule
